// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   Write-back buffer that sits directly in front of the register file
//   write port. The ALU and the load unit each offer results through a
//   valid/ready handshake. Results are queued in order and drained one per
//   cycle onto WE3/A3/WD3.
//
//   Ports
//     CLK, RST                    clock, synchronous active-high reset
//     ALU_VALID/ADDR/DATA/READY   ALU producer handshake
//     MEM_VALID/ADDR/DATA/READY   load-unit producer handshake (has priority)
//     WB_HOLD                     suppresses the drain for this cycle
//     WE3, A3, WD3                register file write port
//     A1, A2                      register file read addresses, used for lookup
//     PEND1, PEND2                a queued, unwritten write to A1/A2 exists
//     BYP1_*, BYP2_*              youngest queued data for A1/A2
//     COUNT                       current occupancy
//
//   Optional feature macro: WB_BYPASS_EN
//     Defined   : the BYP* outputs carry the youngest matching entry.
//     Undefined : the BYP* outputs are tied to 0 and no search logic is built.
//
//   Handshake: a producer raises VALID with ADDR/DATA and holds all three
//   stable until it sees READY high in the same cycle. The transfer happens
//   on the rising edge where VALID && READY. READY depends only on the
//   registered occupancy and on MEM_VALID. It does not depend on a pop in the
//   same cycle, so a full queue refuses new results even while it drains.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ALU_VALID,
    input  logic [AW-1:0]            ALU_ADDR,
    input  logic [DW-1:0]            ALU_DATA,
    output logic                     ALU_READY,
    input  logic                     MEM_VALID,
    input  logic [AW-1:0]            MEM_ADDR,
    input  logic [DW-1:0]            MEM_DATA,
    output logic                     MEM_READY,
    input  logic                     WB_HOLD,
    output logic                     WE3,
    output logic [AW-1:0]            A3,
    output logic [DW-1:0]            WD3,
    input  logic [AW-1:0]            A1,
    input  logic [AW-1:0]            A2,
    output logic                     PEND1,
    output logic                     PEND2,
    output logic                     BYP1_VALID,
    output logic [DW-1:0]            BYP1_DATA,
    output logic                     BYP2_VALID,
    output logic [DW-1:0]            BYP2_DATA,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic          full, mem_push, alu_push, push, pop;
    logic [AW-1:0] push_addr;
    logic [DW-1:0] push_data;

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        MEM_READY = !full;
        ALU_READY = !full && !MEM_VALID;
        mem_push  = MEM_VALID && MEM_READY;
        alu_push  = ALU_VALID && ALU_READY;
        push      = mem_push || alu_push;
        push_addr = mem_push ? MEM_ADDR : ALU_ADDR;
        push_data = mem_push ? MEM_DATA : ALU_DATA;

        WE3   = (count_q != '0) && !WB_HOLD;
        pop   = WE3;
        A3    = (count_q != '0) ? addr_q[rd_ptr_q] : '0;
        WD3   = (count_q != '0) ? data_q[rd_ptr_q] : '0;
        COUNT = count_q;
    end

    // Pending lookup: an entry stays valid until the edge that pops it,
    // so the head being written this cycle still reports as pending.
    always_comb begin
        PEND1 = 1'b0;
        PEND2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == A1)) PEND1 = 1'b1;
            if (vld_q[i] && (addr_q[i] == A2)) PEND2 = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    // Walk the entries from oldest to youngest. A later match overwrites an
    // earlier one, so the youngest matching entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        BYP1_DATA = '0;
        BYP2_DATA = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (vld_q[idx] && (addr_q[idx] == A1)) BYP1_DATA = data_q[idx];
            if (vld_q[idx] && (addr_q[idx] == A2)) BYP2_DATA = data_q[idx];
        end
        BYP1_VALID = PEND1;
        BYP2_VALID = PEND2;
    end
`else
    always_comb begin
        BYP1_VALID = 1'b0;
        BYP1_DATA  = '0;
        BYP2_VALID = 1'b0;
        BYP2_DATA  = '0;
    end
`endif

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // A push and a pop never target the same slot. A push needs a
        // non-full queue and a pop needs a non-empty one, so when both occur
        // the pointers are necessarily different.
        if (push) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry address and data are left untouched by reset. Only the valid
    // flags matter after a reset.
    always_ff @(posedge CLK) begin
        addr_q <= addr_d;
        data_q <= data_d;
        if (RST) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed testbench for regfile_wb_queue. It includes a small register
// file model on the write port, so that it can observe what actually gets
// written.
module tb_regfile_wb_queue;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ALU_VALID, MEM_VALID, WB_HOLD;
    logic [4:0]  ALU_ADDR, MEM_ADDR, A1, A2, A3;
    logic [31:0] ALU_DATA, MEM_DATA, WD3, BYP1_DATA, BYP2_DATA;
    logic        ALU_READY, MEM_READY, WE3, PEND1, PEND2, BYP1_VALID, BYP2_VALID;
    logic [2:0]  COUNT;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rf [32] = '{default: 32'h0};

    regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .CLK(CLK), .RST(RST),
        .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
        .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
        .WB_HOLD(WB_HOLD), .WE3(WE3), .A3(A3), .WD3(WD3), .A1(A1), .A2(A2),
        .PEND1(PEND1), .PEND2(PEND2),
        .BYP1_VALID(BYP1_VALID), .BYP1_DATA(BYP1_DATA),
        .BYP2_VALID(BYP2_VALID), .BYP2_DATA(BYP2_DATA),
        .COUNT(COUNT)
    );

    // Clock and the register file model.
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (WE3) rf[A3] <= WD3;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Each step starts at a falling edge. Inputs are driven there, and the
    // outputs are sampled 1 time unit later, away from the rising edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic alu_drive(input logic v, input logic [4:0] a, input logic [31:0] d);
        ALU_VALID = v;
        ALU_ADDR  = a;
        ALU_DATA  = d;
    endtask

    task automatic mem_drive(input logic v, input logic [4:0] a, input logic [31:0] d);
        MEM_VALID = v;
        MEM_ADDR  = a;
        MEM_DATA  = d;
    endtask

    initial begin
        RST = 1'b1;
        WB_HOLD = 1'b0;
        A1 = 5'd0;
        A2 = 5'd0;
        alu_drive(1'b0, 5'd0, 32'h0);
        mem_drive(1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        tick();
        RST = 1'b0;

        // Reset, then idle.
        A1 = 5'd5;
        A2 = 5'd3;
        #1;
        check("rst_we3", 32'(WE3), 32'd0);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_pend1", 32'(PEND1), 32'd0);
        check("rst_pend2", 32'(PEND2), 32'd0);
        check("rst_alu_ready", 32'(ALU_READY), 32'd1);
        check("rst_mem_ready", 32'(MEM_READY), 32'd1);
        check("rst_byp2_valid", 32'(BYP2_VALID), 32'd0);
        check("rst_a3", 32'(A3), 32'd0);
        tick();

        // Single ALU push, then write-through.
        alu_drive(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        alu_drive(1'b0, 5'd0, 32'h0);
        #1;
        check("single_we3", 32'(WE3), 32'd1);
        check("single_a3", 32'(A3), 32'd5);
        check("single_wd3", WD3, 32'hDEADBEEF);
        check("single_count1", 32'(COUNT), 32'd1);
        check("single_pend1", 32'(PEND1), 32'd1);
        tick();
        #1;
        check("single_count0", 32'(COUNT), 32'd0);
        check("single_we3_off", 32'(WE3), 32'd0);
        check("single_wd3_empty", WD3, 32'h0);
        check("single_rf5", rf[5], 32'hDEADBEEF);
        check("single_pend1_off", 32'(PEND1), 32'd0);

        // ALU and load unit both valid: the load unit goes first.
        alu_drive(1'b1, 5'd3, 32'h11);
        mem_drive(1'b1, 5'd3, 32'h22);
        #1;
        check("arb_mem_ready", 32'(MEM_READY), 32'd1);
        check("arb_alu_ready", 32'(ALU_READY), 32'd0);
        tick();
        mem_drive(1'b0, 5'd0, 32'h0);
        #1;
        check("arb_alu_ready2", 32'(ALU_READY), 32'd1);
        check("arb_wd3_first", WD3, 32'h22);
        check("arb_pend2", 32'(PEND2), 32'd1);
        tick();
        alu_drive(1'b0, 5'd0, 32'h0);
        #1;
        check("arb_rf3_mid", rf[3], 32'h22);
        check("arb_wd3_second", WD3, 32'h11);
        check("arb_count", 32'(COUNT), 32'd1);
        tick();
        #1;
        check("arb_rf3_final", rf[3], 32'h11);
        check("arb_count0", 32'(COUNT), 32'd0);

        // Hold the drain and fill the queue.
        WB_HOLD = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            alu_drive(1'b1, 5'(i), 32'hA0 + 32'(i));
            tick();
        end
        alu_drive(1'b1, 5'd9, 32'h99);
        A1 = 5'd2;
        A2 = 5'd4;
        #1;
        check("full_count", 32'(COUNT), 32'd4);
        check("full_alu_ready", 32'(ALU_READY), 32'd0);
        check("full_mem_ready", 32'(MEM_READY), 32'd0);
        check("full_we3_held", 32'(WE3), 32'd0);
        check("full_pend1_hit", 32'(PEND1), 32'd1);
        check("full_pend2_hit", 32'(PEND2), 32'd1);
        tick();
        alu_drive(1'b0, 5'd0, 32'h0);
        A1 = 5'd7;
        #1;
        check("full_stall_count", 32'(COUNT), 32'd4);
        check("full_pend1_miss", 32'(PEND1), 32'd0);
        WB_HOLD = 1'b0;
        #1;
        check("drain_mem_ready_full", 32'(MEM_READY), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("drain_we3_%0d", i), 32'(WE3), 32'd1);
            check($sformatf("drain_a3_%0d", i), 32'(A3), 32'(i));
            check($sformatf("drain_wd3_%0d", i), WD3, 32'hA0 + 32'(i));
            tick();
        end
        #1;
        check("drain_count0", 32'(COUNT), 32'd0);
        check("drain_rf4", rf[4], 32'hA4);
        check("drain_rf9_untouched", rf[9], 32'h0);

        // Two queued writes to the same register: bypass and ordering.
        WB_HOLD = 1'b1;
        alu_drive(1'b1, 5'd6, 32'h100);
        tick();
        alu_drive(1'b1, 5'd6, 32'h200);
        tick();
        alu_drive(1'b0, 5'd0, 32'h0);
        A1 = 5'd6;
        A2 = 5'd6;
        #1;
        check("byp_pend2", 32'(PEND2), 32'd1);
`ifdef WB_BYPASS_EN
        check("byp2_valid", 32'(BYP2_VALID), 32'd1);
        check("byp2_data", BYP2_DATA, 32'h200);
        check("byp1_data", BYP1_DATA, 32'h200);
`else
        check("byp2_valid", 32'(BYP2_VALID), 32'd0);
        check("byp2_data", BYP2_DATA, 32'h0);
        check("byp1_data", BYP1_DATA, 32'h0);
`endif
        WB_HOLD = 1'b0;
        tick();
        tick();
        #1;
        check("same_addr_rf6", rf[6], 32'h200);
        check("same_addr_count0", 32'(COUNT), 32'd0);

        // Reset while three entries are queued: none of them is written.
        WB_HOLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_drive(1'b1, 5'(8 + i), 32'h800 + 32'(i));
            tick();
        end
        alu_drive(1'b0, 5'd0, 32'h0);
        A1 = 5'd8;
        A2 = 5'd9;
        #1;
        check("prerst_count", 32'(COUNT), 32'd3);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        WB_HOLD = 1'b0;
        #1;
        check("midrst_count", 32'(COUNT), 32'd0);
        check("midrst_we3", 32'(WE3), 32'd0);
        check("midrst_pend1", 32'(PEND1), 32'd0);
        check("midrst_pend2", 32'(PEND2), 32'd0);
        tick();
        tick();
        tick();
        #1;
        check("midrst_rf8", rf[8], 32'h0);
        check("midrst_rf9", rf[9], 32'h0);
        check("midrst_rf10", rf[10], 32'h0);
        check("midrst_ready", 32'(ALU_READY), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back buffer directly upstream of the register file write port.
- Accepts results from two producers, the ALU and the load unit, through a valid/ready handshake.
- Queues results in an in-order FIFO and drains one entry per cycle onto the register file's WE3/A3/WD3 port.
- Reports pending (queued but unwritten) writes for the register file read addresses A1/A2, so hazard logic can stall dependent reads.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 5, register address width; matches A1/A2/A3.
- DW, 32, data width; matches WD3/RD1/RD2.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- ALU_VALID  in  1  ALU result valid.
- ALU_ADDR  in  AW  ALU destination register.
- ALU_DATA  in  DW  ALU result.
- ALU_READY  out  1  ALU result accepted this cycle.
- MEM_VALID  in  1  load result valid.
- MEM_ADDR  in  AW  load destination register.
- MEM_DATA  in  DW  load data.
- MEM_READY  out  1  load result accepted this cycle.
- WB_HOLD  in  1  suppress drain this cycle.
- WE3  out  1  register file write enable.
- A3  out  AW  register file write address.
- WD3  out  DW  register file write data.
- A1  in  AW  lookup address 1 (same net as register file A1).
- A2  in  AW  lookup address 2 (same net as register file A2).
- PEND1  out  1  queued write to A1 exists.
- PEND2  out  1  queued write to A2 exists.
- BYP1_VALID  out  1  bypass hit for A1 (optional feature).
- BYP1_DATA  out  DW  bypass data for A1.
- BYP2_VALID  out  1  bypass hit for A2.
- BYP2_DATA  out  DW  bypass data for A2.
- COUNT  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH entries of {addr, data}, plus read pointer, write pointer and count, all registered. Pointers wrap modulo DEPTH.
- Reset (RST=1 at a rising edge): count=0, pointers=0, all entry valid flags cleared. Entry data is don't-care. Reset applies mid-operation and discards queued entries without writing them.
- After reset: WE3=0, PEND1=PEND2=0, BYP*_VALID=0, COUNT=0, ALU_READY=MEM_READY=1.
- Accept arbitration (combinational):
  - full = (count==DEPTH).
  - MEM has priority: MEM_READY = !full.
  - ALU_READY = !full && !MEM_VALID.
  - At most one push per cycle.
  - A push occurs when (MEM_VALID && MEM_READY) || (ALU_VALID && ALU_READY).
- Ready is independent of the same-cycle pop. A full queue never accepts, even while draining.
- Drain (combinational from registered state):
  - WE3 = (count!=0) && !WB_HOLD.
  - A3/WD3 = head entry; both are 0 when empty.
  - A pop occurs on every edge where WE3=1.
  - Together with the register file, latency is: push at edge N -> write visible in the register file after edge N+1 (no hold, empty queue).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push only: count+1. Pop only: count-1.
- Address 0 writes are queued and drained like any other; no special casing.
- Ordering: strictly FIFO. Two queued writes to the same address drain oldest first, so the last one pushed wins.
- PEND1 = OR over valid entries of (addr==A1); PEND2 likewise for A2. These are purely combinational on A1/A2 and the queue state.
- An entry being popped this cycle still counts as pending this cycle.
- Producers must hold VALID/ADDR/DATA stable until READY. The block does not check this.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - BYP1_VALID = PEND1.
  - BYP1_DATA = data of the youngest valid entry with addr==A1 (closest to the write pointer).
  - BYP2_* likewise for A2.
  - Hazard logic may forward BYP data instead of stalling.
- Undefined: BYP*_VALID=0 and BYP*_DATA=0 constantly; the youngest-match search logic is not built.

Test Plan:
- Reset then idle -> WE3=0, COUNT=0, PEND1=PEND2=0, ALU_READY=MEM_READY=1.
- Single ALU push {addr=5, data=0xDEADBEEF} at edge N, WB_HOLD=0 -> during cycle N..N+1: WE3=1, A3=5, WD3=0xDEADBEEF; COUNT=0 after edge N+1; a register file read of address 5 returns 0xDEADBEEF.
- Simultaneous ALU {3,0x11} and MEM {3,0x22} valid -> MEM accepted first, ALU_READY=0; ALU accepted next cycle. Drain order is 0x22 then 0x11; register 3 ends at 0x11.
- WB_HOLD=1, push 4 entries {addr=1..4, data=0xA1..0xA4} -> COUNT=4, both READY=0, fifth push stalls. A1=2 gives PEND1=1; A1=7 gives PEND1=0. Release hold -> 4 consecutive writes in order, COUNT reaches 0.
- With WB_BYPASS_EN, hold asserted, push {6,0x100} then {6,0x200}, A2=6 -> BYP2_VALID=1, BYP2_DATA=0x200. Without the macro -> BYP2_VALID=0, BYP2_DATA=0.
- Queue holding 3 entries, RST=1 for one edge -> COUNT=0, WE3=0, PEND*=0 next cycle; none of the 3 entries is written.
